msix_irq_aggregator: RTL and testbench

//  Collects interrupt events from NUM_SRC function-level sources, latches them as MSI-X pending bits,

---
 rtl/msix_irq_agg_pkg.sv | 20 ++
 rtl/msix_irq_agg_if.sv | 13 +
 rtl/msix_irq_agg_rr_arb.sv | 30 +++
 rtl/msix_irq_aggregator.sv | 115 +++++++++++
 tb/tb_msix_irq_aggregator.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/msix_irq_agg_pkg.sv
// Shared types and helpers for the MSI-X interrupt aggregator.
// MSIX_IRQ_AGG_THROTTLE_EN (in the top) enables the GAP/throttle state.
package msix_irq_agg_pkg;

    localparam int MSIX_VEC_W = 16;
    localparam int COALESCE_W = 16;

    typedef enum logic {
        ARB = 1'b0,
        GAP = 1'b1
    } agg_state_e;

    function automatic logic [COALESCE_W-1:0] sat_add(input logic [COALESCE_W-1:0] a,
                                                      input logic [COALESCE_W-1:0] b);
        logic [COALESCE_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[COALESCE_W] ? '1 : s[COALESCE_W-1:0];
    endfunction

endpackage

// File: rtl/msix_irq_agg_if.sv
// Request port toward the AXI-S Tx MSI-X bridge: one-cycle strobe plus vector number,
// with a level ready coming back from the bridge.
interface msix_irq_agg_if;
    import msix_irq_agg_pkg::*;

    logic                  msix_strb;
    logic [MSIX_VEC_W-1:0] msix_num;
    logic                  msix_ready;

    modport master (output msix_strb, output msix_num, input  msix_ready);
    modport slave  (input  msix_strb, input  msix_num, output msix_ready);

endinterface

// File: rtl/msix_irq_agg_rr_arb.sv
// Round-robin picker: first set request at or after ptr, wrapping NUM_SRC-1 -> 0.
module msix_rr_arb #(
    parameter  int NUM_SRC = 8,
    localparam int IDX_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_SRC-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    always_comb begin
        int j;
        j     = 0;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            j = int'(ptr) + k;
            if (j >= NUM_SRC) j = j - NUM_SRC;
            if (!any && req[j]) begin
                any      = 1'b1;
                idx      = IDX_W'(j);
                grant[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/msix_irq_aggregator.sv
// Latches per-source interrupt events as MSI-X pending bits and issues them round-robin
// to the Tx MSI-X bridge. Define MSIX_IRQ_AGG_THROTTLE_EN to enforce THROTTLE_CYCLES spacing.
module msix_irq_aggregator
    import msix_irq_agg_pkg::*;
#(
    parameter int                    NUM_SRC         = 8,
    parameter logic [MSIX_VEC_W-1:0] VEC_BASE        = '0,
    parameter int                    THROTTLE_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_SRC-1:0]    irq_req,
    input  logic [NUM_SRC-1:0]    irq_mask,
    output logic [NUM_SRC-1:0]    irq_pending,
    output logic [COALESCE_W-1:0] coalesce_cnt,
    input  logic                  coalesce_clr,
    msix_irq_agg_if.master        bus
);

    localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    if (NUM_SRC < 1 || NUM_SRC > 64 || THROTTLE_CYCLES < 1) begin : g_bad_cfg
        $error("msix_irq_aggregator: NUM_SRC must be 1..64 and THROTTLE_CYCLES >= 1");
    end

    logic [NUM_SRC-1:0]    pending, eligible, grant, clr_vec, merged;
    logic [IDX_W-1:0]      rr_ptr, win_idx;
    logic                  win_any, can_issue, issue;
    logic [COALESCE_W-1:0] merge_cnt, cnt;
    logic                  strb_q;
    logic [MSIX_VEC_W-1:0] num_q;

    assign eligible = pending & ~irq_mask;

    msix_rr_arb #(.NUM_SRC(NUM_SRC)) u_arb (
        .req   (eligible),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (win_idx),
        .any   (win_any)
    );

    assign issue   = can_issue && bus.msix_ready && win_any;
    assign clr_vec = issue ? grant : '0;
    // A re-request in the issue cycle re-arms the bit and is not a merge.
    assign merged  = irq_req & pending & ~clr_vec;

    always_comb begin
        merge_cnt = '0;
        for (int i = 0; i < NUM_SRC; i++)
            merge_cnt = merge_cnt + COALESCE_W'(merged[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
            cnt     <= '0;
            rr_ptr  <= '0;
            strb_q  <= 1'b0;
            num_q   <= '0;
        end else begin
            pending <= (pending & ~clr_vec) | irq_req;
            cnt     <= coalesce_clr ? '0 : sat_add(cnt, merge_cnt);
            strb_q  <= issue;
            if (issue) begin
                num_q  <= VEC_BASE + MSIX_VEC_W'(win_idx);
                rr_ptr <= (win_idx == IDX_W'(NUM_SRC - 1)) ? '0 : win_idx + IDX_W'(1);
            end
        end
    end

`ifdef MSIX_IRQ_AGG_THROTTLE_EN
    localparam int TCNT_W = $clog2(THROTTLE_CYCLES + 1);

    agg_state_e        state, state_nxt;
    logic [TCNT_W-1:0] tcnt, tcnt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ARB;
            tcnt  <= '0;
        end else begin
            state <= state_nxt;
            tcnt  <= tcnt_nxt;
        end
    end

    assign can_issue = (state == ARB);

    // GAP lasts THROTTLE_CYCLES-1 clocks so issues land exactly THROTTLE_CYCLES apart.
    always_comb begin
        state_nxt = state;
        tcnt_nxt  = tcnt;
        case (state)
            ARB: if (issue && THROTTLE_CYCLES > 1) begin
                state_nxt = GAP;
                tcnt_nxt  = TCNT_W'(THROTTLE_CYCLES - 1);
            end
            GAP: begin
                tcnt_nxt = tcnt - TCNT_W'(1);
                if (tcnt <= TCNT_W'(1)) state_nxt = ARB;
            end
            default: state_nxt = ARB;
        endcase
    end
`else
    assign can_issue = 1'b1;
`endif

    assign irq_pending   = pending;
    assign coalesce_cnt  = cnt;
    assign bus.msix_strb = strb_q;
    assign bus.msix_num  = num_q;

endmodule

// File: tb/tb_msix_irq_aggregator.sv
// Scoreboard bench for msix_irq_aggregator: expected vector numbers are queued on stimulus
// and popped as strobes appear; timing, PBA and coalesce counter are checked alongside.
module tb_msix_irq_aggregator;
    import msix_irq_agg_pkg::*;

    localparam int          N    = 8;
    localparam logic [15:0] BASE = 16'h0020;
`ifdef MSIX_IRQ_AGG_THROTTLE_EN
    localparam int SPACE = 16;
`else
    localparam int SPACE = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [N-1:0] irq_req = '0, irq_mask = '0, irq_pending;
    logic [15:0] coalesce_cnt;
    logic        coalesce_clr = 1'b0;

    int n_tests = 0, n_fail = 0;
    int cyc = 0, c0 = 0, m_ptr = 0;
    logic [15:0] exp_q[$];
    int          strb_cyc[$];

    msix_irq_agg_if bus();

    msix_irq_aggregator #(.NUM_SRC(N), .VEC_BASE(BASE), .THROTTLE_CYCLES(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .irq_req      (irq_req),
        .irq_mask     (irq_mask),
        .irq_pending  (irq_pending),
        .coalesce_cnt (coalesce_cnt),
        .coalesce_clr (coalesce_clr),
        .bus          (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.msix_strb) begin
            strb_cyc.push_back(cyc);
            if (exp_q.size() == 0) chk("spurious_strb", 32'(bus.msix_num), 32'hffff_ffff);
            else                   chk("msix_num", 32'(bus.msix_num), 32'(exp_q.pop_front()));
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference round-robin order for a set of sources that all become pending together.
    task automatic expect_set(input logic [N-1:0] set);
        int last;
        last = m_ptr;
        for (int k = 0; k < N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (set[j]) begin
                exp_q.push_back(BASE + 16'(j));
                last = j;
            end
        end
        m_ptr = (last + 1) % N;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) step();
        if (exp_q.size() != 0) begin
            chk("drain_timeout", 32'(exp_q.size()), 0);
            exp_q.delete();
        end
        step(SPACE + 4);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.msix_ready = 1'b1;
        step(2);
        chk("rst_pending", 32'(irq_pending), 0);
        chk("rst_strb", 32'(bus.msix_strb), 0);
        chk("rst_num", 32'(bus.msix_num), 0);
        chk("rst_cnt", 32'(coalesce_cnt), 0);
        rst_n = 1'b1;
        step();

        // single source, latency 2
        strb_cyc.delete();
        expect_set(8'h08);
        irq_req = 8'h08; c0 = cyc; step(); irq_req = '0;
        drain();
        chk("t1_count", 32'(strb_cyc.size()), 1);
        chk("t1_latency", 32'(strb_cyc[0] - c0), 2);
        chk("t1_pending", 32'(irq_pending), 0);

        // all-source bursts, rr order continues after last winner
        for (int r = 0; r < 2; r++) begin
            strb_cyc.delete();
            expect_set(8'hFF);
            irq_req = 8'hFF; step(); irq_req = '0;
            drain();
            chk("t2_count", 32'(strb_cyc.size()), 8);
            chk("t2_span", 32'(strb_cyc[7] - strb_cyc[0]), 32'(7 * SPACE));
        end

        // masked source stays pending, issues once unmasked
        irq_mask = 8'h04; irq_req = 8'h04; step(); irq_req = '0;
        strb_cyc.delete();
        step(4);
        chk("t3_masked_nostrb", 32'(strb_cyc.size()), 0);
        chk("t3_pba", 32'(irq_pending), 32'h04);
        expect_set(8'h04);
        irq_mask = '0; c0 = cyc;
        step(3);
        chk("t3_unmask_lat", 32'(strb_cyc.size() == 1 && (strb_cyc[0] - c0) <= 2), 1);
        drain();

        // ready low: coalescing, single strobe on release, clear, saturation
        bus.msix_ready = 1'b0;
        strb_cyc.delete();
        irq_req = 8'h02; step(5); irq_req = '0;
        step(2);
        chk("t4_nostrb", 32'(strb_cyc.size()), 0);
        chk("t4_cnt4", 32'(coalesce_cnt), 4);
        chk("t4_pba", 32'(irq_pending), 32'h02);
        expect_set(8'h02);
        bus.msix_ready = 1'b1;
        drain();
        chk("t4_one_strb", 32'(strb_cyc.size()), 1);
        coalesce_clr = 1'b1; step(); coalesce_clr = 1'b0;
        chk("t4_clr", 32'(coalesce_cnt), 0);
        bus.msix_ready = 1'b0;
        irq_req = 8'hFF; step(8800);
        chk("t4_sat", 32'(coalesce_cnt), 32'hFFFF);
        coalesce_clr = 1'b1; step();
        chk("t4_clr_prio", 32'(coalesce_cnt), 0);
        coalesce_clr = 1'b0; irq_req = '0; step();
        chk("t4_after_clr", 32'(coalesce_cnt), 0);
        expect_set(8'hFF);
        bus.msix_ready = 1'b1;
        drain();

        // re-request in the issue cycle keeps the bit pending, no merge counted
        strb_cyc.delete();
        expect_set(8'h20);
        expect_set(8'h20);
        irq_req = 8'h20; step(); step(); irq_req = '0;
        @(negedge clk);
        chk("t5_rearm", 32'(irq_pending[5]), 1);
        drain();
        chk("t5_two_strb", 32'(strb_cyc.size()), 2);
        chk("t5_cnt", 32'(coalesce_cnt), 0);

        // async reset mid-stream (mid-GAP when throttled)
        strb_cyc.delete();
        expect_set(8'hFF);
        irq_req = 8'hFF; step(); irq_req = '0;
        for (int i = 0; i < 200 && strb_cyc.size() < 3; i++) step();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_strb", 32'(bus.msix_strb), 0);
        chk("arst_num", 32'(bus.msix_num), 0);
        chk("arst_pba", 32'(irq_pending), 0);
        exp_q.delete();
        m_ptr = 0;
        step(2);
        rst_n = 1'b1;
        strb_cyc.delete();
        expect_set(8'h41);
        irq_req = 8'h41; c0 = cyc; step(); irq_req = '0;
        drain();
        chk("arst_arb_lat", 32'(strb_cyc[0] - c0), 2);
        chk("arst_count", 32'(strb_cyc.size()), 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
